instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch-side initiator for the synchronous instruction memory. Owns the fetch PC and drives the 5-bit word address into instr_memory. Absorbs the memory's one-cycle read latency and hands instructions to decode over a valid/ready interface through a 2-entry buffer. Supports PC redirect for branches/jumps and a halt input.

Parameters:
ADDR_W, 5, word-address width; memory depth is 2^ADDR_W words
INSTR_W, 32, instruction width
RESET_PC, 0, fetch address after reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_addr  output  ADDR_W  word address to instr_memory; equals the fetch_pc register
imem_req  output  1  high in cycles where a fetch is issued (informational; the memory has no enable)
imem_rdata  input  INSTR_W  memory read data, valid the cycle after the address was issued
redirect_valid  input  1  load redirect_pc and flush all fetched or in-flight instructions
redirect_pc  input  ADDR_W  new fetch address
halt  input  1  suppress new issues; buffered and in-flight instructions still deliver
out_valid  output  1  out_instr/out_pc hold a valid instruction
out_ready  input  1  consumer accepts when out_valid && out_ready
out_instr  output  INSTR_W  instruction at buffer head; 0 when out_valid=0
out_pc  output  ADDR_W  word address of out_instr; 0 when out_valid=0

Behaviour:
- Memory timing: address issued in cycle N (imem_req=1) is sampled at the end of N. Data is on imem_rdata in N+1 and is written into the buffer at the end of N+1.
- State:
  - fetch_pc (ADDR_W)
  - inflight flag plus inflight_pc
  - 2-entry FIFO of {instr, pc} with count 0..2
- Reset (rst=1 at a clock edge): fetch_pc=RESET_PC, inflight=0, count=0, out_valid=0, out_instr=0, out_pc=0. Any in-flight read is dropped.
- Issue rule: issue = !rst && !redirect_valid && !halt && (count + inflight - pop) < 2, where pop = out_valid && out_ready.
- On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 mod 2^ADDR_W (31 wraps to 0). Without issue, inflight<=0.
- Landing: if inflight=1 in a cycle, push {imem_rdata, inflight_pc} into the FIFO at the end of that cycle.
- Push and pop in the same cycle: count unchanged, entries shift correctly. Push at count=2 occurs only with a simultaneous pop (guaranteed by the issue rule).
- Throughput: with out_ready held high and halt=0, one instruction per cycle in steady state.
- Latency: first low-rst cycle C issues RESET_PC, out_valid rises in C+2.
- out_valid = (count != 0). The head entry is stable while out_valid && !out_ready.
- Redirect (priority over everything except rst), asserted in cycle R:
  - end of R: count<=0, inflight<=0, fetch_pc<=redirect_pc, no issue.
  - Data landing in R+1 from a pre-redirect issue is discarded.
  - A handshake completing in R counts as consumed.
  - R+1 issues redirect_pc; out_valid=0 in R+1 and R+2; out_valid=1 with out_pc=redirect_pc in R+3.
- Back-to-back redirects: the last one wins; each restarts the sequence above.
- Halt: while halt=1, imem_req=0 and fetch_pc holds. Halt and redirect together: fetch_pc loads and the flush happens, but no issue occurs until halt drops.
- imem_addr is always driven from fetch_pc. Reads in non-issue cycles are ignored.

Test Plan:
1. Bench memory returns 32'hA000_0000|addr. Release rst, hold out_ready=1 → out_valid from the 3rd cycle; out_pc 0,1,2,... with out_instr 32'hA000_0000, 32'hA000_0001,... every cycle, no gaps.
2. Wrap: RESET_PC=30, free run → out_pc sequence 30,31,0,1 and out_instr matches each.
3. Backpressure: out_ready=0 for 5 cycles from steady state → count saturates at 2, imem_req=0, head pc stable. Release ready → next pcs delivered in order, no loss or duplication.
4. Redirect: redirect_valid=1 with redirect_pc=12 while count=2 and inflight=1 → out_valid=0 for 2 cycles, then out_pc=12 with out_instr 32'hA000_000C, then 13, 14. No pre-redirect pc appears.
5. Halt: assert halt for 4 cycles with out_ready=1 → buffered and in-flight instructions drain, out_valid drops, imem_req=0. Deassert halt → fetch resumes at the next sequential pc.
6. Reset mid-stream: assert rst for 1 cycle while count=2 → outputs 0 next cycle; fetch restarts at RESET_PC and out_pc=RESET_PC 2 cycles after rst drops.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues word addresses to a
// one-cycle-latency synchronous instruction memory, and delivers fetched
// instructions to decode through a 2-entry buffer.
//
// Output handshake: out_valid stays high and out_instr/out_pc stay stable
// until the cycle where out_ready is also high. That cycle is the transfer.
// The consumer may assert or drop out_ready freely.
//
// A read issued in cycle N lands in the buffer at the end of N+1. The issue
// rule reserves a buffer slot for every read in flight, so a landing never
// finds the buffer full unless the head is popped in the same cycle.
// A redirect flushes the buffer and cancels any read in flight. The cancelled
// read still returns data in the next cycle, but that data is ignored because
// the in-flight flag was cleared.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 5,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_req,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic [1:0]         count_q, count_d;
    logic [INSTR_W-1:0] head_instr_q, head_instr_d;
    logic [ADDR_W-1:0]  head_pc_q, head_pc_d;
    logic [INSTR_W-1:0] tail_instr_q, tail_instr_d;
    logic [ADDR_W-1:0]  tail_pc_q, tail_pc_d;

    logic               pop;
    logic               issue;
    logic [2:0]         occupancy;
    logic [1:0]         level;

    // Issue decision and next-state computation for the PC and the buffer.
    always_comb begin
        pop       = (count_q != 2'd0) && out_ready;
        // The count of slots that are full or reserved after this cycle's pop.
        // A pop implies count_q >= 1, so this value cannot go below zero.
        occupancy = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
        issue     = !rst && !redirect_valid && !halt && (occupancy < 3'd2);

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        head_instr_d  = head_instr_q;
        head_pc_d     = head_pc_q;
        tail_instr_d  = tail_instr_q;
        tail_pc_d     = tail_pc_q;
        level         = count_q - {1'b0, pop};

        if (redirect_valid) begin
            // Flush everything. Dropping inflight discards the read that lands next cycle.
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            count_d    = 2'd0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 1'b1;
            end

            // When the head is popped, the tail moves up. If the buffer held one entry, the tail is stale but unused.
            if (pop) begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
            end

            // The returning read goes into the first free slot that remains after the pop.
            if (inflight_q) begin
                if (level == 2'd0) begin
                    head_instr_d = imem_rdata;
                    head_pc_d    = inflight_pc_q;
                end else begin
                    tail_instr_d = imem_rdata;
                    tail_pc_d    = inflight_pc_q;
                end
            end

            count_d = level + {1'b0, inflight_q};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            head_instr_q  <= '0;
            head_pc_q     <= '0;
            tail_instr_q  <= '0;
            tail_pc_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            head_instr_q  <= head_instr_d;
            head_pc_q     <= head_pc_d;
            tail_instr_q  <= tail_instr_d;
            tail_pc_q     <= tail_pc_d;
        end
    end

    // Output decode. Data outputs read zero whenever no instruction is presented.
    always_comb begin
        imem_addr = fetch_pc_q;
        imem_req  = issue;
        out_valid = (count_q != 2'd0);
        out_instr = out_valid ? head_instr_q : '0;
        out_pc    = out_valid ? head_pc_q : '0;
    end

endmodule
